dpram_be: RTL and testbench
===========================

# dpram_be

Parametrised dual-port RAM with byte-lane write enables, same-address write-first forwarding, optional output register and a built-in fill engine that clears the array after reset or on request. It is the general-purpose successor to the plain single-clock dual-port RAM used by the video path. Typical uses are line buffers, palette and scroll RAMs, and sprite tables that must start from a known value without a CPU-driven clear loop.

## Interface
- ADDR_WIDTH, 9, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 16, word width; must be a multiple of LANES (elaboration error otherwise)
- LANES, 2, number of write-enable lanes; lane width LW = DATA_WIDTH/LANES
- OUT_REG, 0, 0 = read latency 1; 1 = read latency 2 (extra output register)
- FILL, 0, DATA_WIDTH-wide word written to every location by the fill engine
- CLEAR_ON_RESET, 1, 1 = fill engine starts automatically when reset deasserts
- clk  in  1  single clock; all logic is on its rising edge
- reset  in  1  asynchronous, active-high
- clr  in  1  pulse that starts or restarts a full-array fill
- busy  out  1  fill in progress
- we  in  1  write request
- wbe  in  LANES  lane enables; lane i covers wd[i*LW +: LW]
- wa  in  ADDR_WIDTH  write address
- wd  in  DATA_WIDTH  write data
- re  in  1  read request
- ra  in  ADDR_WIDTH  read address
- rd  out  DATA_WIDTH  read data; forced to 0 whenever rd_valid=0
- rd_valid  out  1  rd holds the result of an accepted read

## Operation
- Clock and reset are fixed: one clock `clk`; `reset` is asynchronous and active-high.
- Fill FSM, states IDLE and FILL. There is also a counter `fcnt` of ADDR_WIDTH bits.
  - In FILL, location `fcnt` is written with FILL on every lane each cycle and `fcnt` increments.
  - FILL goes to IDLE on the cycle that writes address 2**ADDR_WIDTH-1.
  - `clr` seen in either state: go to FILL with `fcnt`=0. A `clr` during FILL restarts from 0.
- busy = (state==FILL).
- While busy, user writes are dropped with no effect. User reads are accepted by the RAM but produce rd_valid=0.
- User write: when we=1 and !busy, each lane with wbe[i]=1 is updated. Lanes with wbe[i]=0 keep their contents. we=1 with wbe=0 is a no-op.
- User read: when re=1 and !busy, the word at ra is returned after the latency in Timing. re=0 produces no rd_valid.
- Collision (same cycle, re and we, ra==wa, !busy): write-first per lane.
  - Enabled lanes return the new wd.
  - Disabled lanes return the old stored value.
  - The array primitive has no read-write check, so forwarding is done by registering the hit flag, wbe and wd alongside the read and merging them at the output.
- A write in the cycle after a read to the same address does not affect that read: old data is returned.
- reset asserted, including mid-fill:
  - state = FILL if CLEAR_ON_RESET, else IDLE
  - fcnt = 0; all pipeline valids = 0
  - array contents are not reset

## Timing
- Reset values: busy = CLEAR_ON_RESET, rd_valid = 0, rd = 0, internal pipeline valids = 0.
- First fill write happens on the first rising edge after reset deasserts.
- Fill duration: exactly 2**ADDR_WIDTH cycles with busy=1. busy falls in the cycle after the last fill write.
- OUT_REG=0: read accepted at edge N → rd/rd_valid valid after edge N+1, for one cycle per read.
- OUT_REG=1: read accepted at edge N → rd/rd_valid valid after edge N+2.
- Back-to-back reads on consecutive cycles give consecutive rd_valid pulses; there is no stall and no backpressure.
- A read accepted in the last fill cycle has busy=1, so it returns rd_valid=0. The first valid read is one issued in the cycle after busy falls.
- The fill write port and the user write port share the array's single write port. Fill has priority, which is why user writes are dropped while busy.

## Structure
- Package `pgm_mem_pkg`: fill FSM state enum {IDLE, FILL} and a lane-merge function (old, new, be) → word.
- Sub-module `dpram_be_core`: bare array with one lane-enabled write port and one registered read port, with the M10K/no_rw_check attribute. It contains no reset, no forwarding and no FSM.
- Top level `dpram_be` holds the fill FSM, write-port mux, collision detection, forwarding pipeline, OUT_REG stage and rd gating.

## Test plan
- Reset with ADDR_WIDTH=4, FILL=16'hA5A5, CLEAR_ON_RESET=1 → busy=1 for exactly 16 cycles. Afterwards, reading all 16 addresses returns A5A5, each with rd_valid one cycle after re (OUT_REG=0).
- Write addr 3, wd=16'h1234, wbe=2'b11; then write addr 3, wd=16'hFFFF, wbe=2'b01; read 3 → 16'h12FF.
- Same cycle: write addr 5 with wd=16'hBEEF, wbe=2'b10 (old value 16'h0000) and read addr 5 → rd=16'hBE00. The next read of 5 also returns 16'hBE00.
- Pulse clr halfway through a fill → fcnt restarts and busy stays high for 16 more cycles. A user write issued while busy leaves the location at FILL.
- OUT_REG=1: reads to addresses 0,1,2 on consecutive cycles → three consecutive rd_valid pulses starting 2 cycles after the first re, with correct data in order.
- Assert reset mid-fill and mid-read → rd_valid=0 and rd=0 immediately (asynchronously); the fill restarts from address 0 after reset deasserts.

Source files
------------

// File: rtl/dpram_be_pkg.sv
// Shared types and helpers for the byte-lane dual-port RAM.
package pgm_mem_pkg;

  // Fill engine states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Upper bounds for the lane-merge helper operands
  localparam int unsigned MAX_DW    = 256;
  localparam int unsigned MAX_LANES = 32;

  // Per-lane select: lanes with be set take new_w, the rest keep old_w
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0]    old_w,
    input logic [MAX_DW-1:0]    new_w,
    input logic [MAX_LANES-1:0] be,
    input int unsigned          lw
  );
    logic [MAX_DW-1:0] res;
    res = old_w;
    for (int unsigned b = 0; b < MAX_DW; b++) begin
      if (be[5'(b / lw)]) res[b] = new_w[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_be_core.sv
// Bare array: one lane-enabled write port, one registered read port.
module dpram_be_core #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LANES      = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LW    = DATA_WIDTH / LANES;

  (* ramstyle = "M10K, no_rw_check" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Lane-enabled write
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (be[i]) mem[wa][i*LW +: LW] <= wd[i*LW +: LW];
      end
    end
  end

  // Registered read; same-address collisions return stored (old) data
  always_ff @(posedge clk) begin
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/dpram_be.sv
// Dual-port RAM with lane enables, write-first forwarding, optional
// output register and a fill engine that clears the array.
module dpram_be
  import pgm_mem_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 9,
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           LANES          = 2,
  parameter int unsigned           OUT_REG        = 0,
  parameter logic [DATA_WIDTH-1:0] FILL           = '0,
  parameter bit                    CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  output logic                  busy,
  input  logic                  we,
  input  logic [LANES-1:0]      wbe,
  input  logic [ADDR_WIDTH-1:0] wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] ra,
  output logic [DATA_WIDTH-1:0] rd,
  output logic                  rd_valid
);

  localparam int unsigned           LW        = DATA_WIDTH / LANES;
  localparam logic [ADDR_WIDTH-1:0] FCNT_LAST = '1;

  // Parameter sanity
  if (DATA_WIDTH % LANES != 0) begin : g_bad_lanes
    $error("dpram_be: DATA_WIDTH must be a multiple of LANES");
  end
  if (DATA_WIDTH > MAX_DW || LANES > MAX_LANES) begin : g_bad_size
    $error("dpram_be: DATA_WIDTH or LANES exceeds lane_merge limits");
  end

  fill_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] fcnt, fcnt_nxt;

  logic                  mem_we_c;
  logic [LANES-1:0]      mem_be_c;
  logic [ADDR_WIDTH-1:0] mem_wa_c;
  logic [DATA_WIDTH-1:0] mem_wd_c;
  logic [DATA_WIDTH-1:0] mem_q;

  logic                  rd_acc_c;
  logic                  hit_c;
  logic                  v1;
  logic [LANES-1:0]      fwd_be1;
  logic [DATA_WIDTH-1:0] fwd_wd1;
  logic [DATA_WIDTH-1:0] merged_c;

  // Fill state register; reset optionally launches a fill
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? pgm_mem_pkg::FILL : pgm_mem_pkg::IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next state: walk the array once, clr (re)starts from address 0
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    case (state)
      pgm_mem_pkg::IDLE: ;
      pgm_mem_pkg::FILL: begin
        fcnt_nxt = fcnt + ADDR_WIDTH'(1);
        if (fcnt == FCNT_LAST) state_nxt = pgm_mem_pkg::IDLE;
      end
      default: state_nxt = pgm_mem_pkg::IDLE;
    endcase
    if (clr) begin
      state_nxt = pgm_mem_pkg::FILL;
      fcnt_nxt  = '0;
    end
  end

  // FSM outputs: busy flag and write-port mux (fill has priority)
  always_comb begin
    busy     = (state == pgm_mem_pkg::FILL);
    mem_we_c = we;
    mem_be_c = wbe;
    mem_wa_c = wa;
    mem_wd_c = wd;
    if (state == pgm_mem_pkg::FILL) begin
      mem_we_c = 1'b1;
      mem_be_c = '1;
      mem_wa_c = fcnt;
      mem_wd_c = FILL;
    end
  end

  dpram_be_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES)
  ) u_core (
    .clk (clk),
    .we  (mem_we_c),
    .be  (mem_be_c),
    .wa  (mem_wa_c),
    .wd  (mem_wd_c),
    .re  (re),
    .ra  (ra),
    .q   (mem_q)
  );

  // Accepted read and same-address write collision
  always_comb begin
    rd_acc_c = re && !busy;
    hit_c    = rd_acc_c && we && (ra == wa);
  end

  // Forwarding info travels alongside the array read
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      fwd_be1 <= '0;
      fwd_wd1 <= '0;
    end else begin
      v1      <= rd_acc_c;
      fwd_be1 <= hit_c ? wbe : '0;
      fwd_wd1 <= wd;
    end
  end

  // Write-first merge: forwarded lanes override the stored word
  always_comb begin
    merged_c = DATA_WIDTH'(lane_merge(MAX_DW'(mem_q), MAX_DW'(fwd_wd1),
                                      MAX_LANES'(fwd_be1), LW));
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  v2;
    logic [DATA_WIDTH-1:0] d2;

    // Extra output stage
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        d2 <= v1 ? merged_c : '0;
      end
    end

    // Gate read data with its valid
    always_comb begin
      rd_valid = v2;
      rd       = v2 ? d2 : '0;
    end
  end else begin : g_noreg
    // Gate read data with its valid
    always_comb begin
      rd_valid = v1;
      rd       = v1 ? merged_c : '0;
    end
  end

endmodule

// File: tb/tb_dpram_be.sv
// Randomised bench for dpram_be: two instances (latency 1 and 2) share
// stimulus and are compared against a word/lane-level memory model.
module tb_dpram_be;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 16;
  localparam int unsigned LN    = 2;
  localparam int unsigned LWB   = DW / LN;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam logic [DW-1:0] FILLV = 16'hA5A5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [LN-1:0] wbe = '0;
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic [DW-1:0] wd = '0;

  logic          busy0, busy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] mem_m [DEPTH];
  int            fill_left;
  logic          ev_a, ev_b;
  logic [DW-1:0] ed_a, ed_b;

  always #5 clk = ~clk;

  dpram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .OUT_REG(0),
    .FILL(FILLV), .CLEAR_ON_RESET(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy0),
    .we(we), .wbe(wbe), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd0), .rd_valid(rv0)
  );

  dpram_be #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LN), .OUT_REG(1),
    .FILL(FILLV), .CLEAR_ON_RESET(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .busy(busy1),
    .we(we), .wbe(wbe), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd1), .rd_valid(rv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    fill_left = DEPTH;
    ev_a = 1'b0; ed_a = '0;
    ev_b = 1'b0; ed_b = '0;
  endtask

  task automatic check_outputs();
    check("busy0", 32'(busy0), 32'(fill_left > 0));
    check("busy1", 32'(busy1), 32'(fill_left > 0));
    check("rv0",   32'(rv0),   32'(ev_a));
    check("rd0",   32'(rd0),   32'(ed_a));
    check("rv1",   32'(rv1),   32'(ev_b));
    check("rd1",   32'(rd1),   32'(ed_b));
  endtask

  // One clock edge: apply the model to the inputs seen at the edge
  task automatic step();
    logic          v;
    logic [DW-1:0] d;
    @(posedge clk);
    ev_b = ev_a;
    ed_b = ed_a;
    if (re && fill_left == 0) begin
      v = 1'b1;
      d = mem_m[ra];
      if (we && wa == ra) begin
        for (int l = 0; l < LN; l++) if (wbe[l]) d[l*LWB +: LWB] = wd[l*LWB +: LWB];
      end
    end else begin
      v = 1'b0;
      d = '0;
    end
    ev_a = v;
    ed_a = d;
    if (fill_left > 0) begin
      mem_m[DEPTH - fill_left] = FILLV;
      fill_left--;
    end else if (we) begin
      for (int l = 0; l < LN; l++) if (wbe[l]) mem_m[wa][l*LWB +: LWB] = wd[l*LWB +: LWB];
    end
    if (clr) fill_left = DEPTH;
    #1;
    check_outputs();
  endtask

  task automatic idle();
    clr = 1'b0; we = 1'b0; re = 1'b0; wbe = '0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] be);
    idle(); we = 1'b1; wa = a; wd = d; wbe = be;
    step();
    idle();
  endtask

  task automatic read(input logic [AW-1:0] a);
    idle(); re = 1'b1; ra = a;
    step();
    idle();
  endtask

  // Asynchronous reset pulse between edges
  task automatic pulse_reset(input string tag);
    reset = 1'b1;
    #1;
    check({tag, "_rv0"}, 32'(rv0), 32'd0);
    check({tag, "_rd0"}, 32'(rd0), 32'd0);
    check({tag, "_rv1"}, 32'(rv1), 32'd0);
    check({tag, "_rd1"}, 32'(rd1), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy0", 32'(busy0), 32'd1);
    check("rst_busy1", 32'(busy1), 32'd1);
    check("rst_rv0",   32'(rv0),   32'd0);
    check("rst_rd0",   32'(rd0),   32'd0);
    check("rst_rv1",   32'(rv1),   32'd0);
    reset = 1'b0;
    model_reset();

    // Power-up fill: count busy cycles
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (busy0) busy_cycles++;
      step();
    end
    check("fill_len", 32'(busy_cycles), 32'(DEPTH));

    // Read back the filled array
    for (int a = 0; a < DEPTH; a++) begin
      read(AW'(a));
      check("fill_data", 32'(rd0), 32'(FILLV));
    end
    step(); step();

    // Partial lane overwrite
    write(4'd3, 16'h1234, 2'b11);
    write(4'd3, 16'hFFFF, 2'b01);
    read(4'd3);
    check("lane_merge", 32'(rd0), 32'h12FF);
    step(); step();

    // Same-cycle collision: write-first per lane
    write(4'd5, 16'h0000, 2'b11);
    idle(); we = 1'b1; wa = 4'd5; wd = 16'hBEEF; wbe = 2'b10; re = 1'b1; ra = 4'd5;
    step();
    idle();
    check("collide", 32'(rd0), 32'hBE00);
    read(4'd5);
    check("collide_after", 32'(rd0), 32'hBE00);
    step(); step();

    // Write the cycle after a read: read sees old data
    read(4'd7);
    check("rd_then_wr", 32'(rd0), 32'(FILLV));
    write(4'd7, 16'h0F0F, 2'b11);
    step(); step();

    // OUT_REG=1 back-to-back reads
    write(4'd1, 16'h1111, 2'b11);
    write(4'd2, 16'h2222, 2'b11);
    write(4'd0, 16'h0000, 2'b11);
    idle(); re = 1'b1; ra = 4'd0; step();
    ra = 4'd1; step();
    check("b2b_first1", 32'(rv1), 32'd1);
    ra = 4'd2; step();
    idle(); step();
    check("b2b_last1", 32'(rd1), 32'h2222);
    step(); step();

    // clr mid-fill restart, user write dropped while busy
    clr = 1'b1; step(); idle();
    for (int i = 0; i < 8; i++) step();
    write(4'd9, 16'h5555, 2'b11);
    clr = 1'b1; step(); idle();
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (busy0) busy_cycles++;
      step();
    end
    check("restart_len", 32'(busy_cycles), 32'(DEPTH));
    read(4'd9);
    check("dropped_wr", 32'(rd0), 32'(FILLV));
    step(); step();

    // Reset mid-read and mid-fill
    write(4'd2, 16'h7777, 2'b11);
    read(4'd2);
    pulse_reset("rst_read");
    for (int i = 0; i < 5; i++) step();
    pulse_reset("rst_fill");
    for (int i = 0; i < DEPTH + 1; i++) step();
    read(4'd2);
    check("refill", 32'(rd0), 32'(FILLV));
    step(); step();

    // Randomised traffic on a narrow address range
    for (int i = 0; i < 600; i++) begin
      we  = 1'($urandom_range(0, 1));
      wbe = LN'($urandom);
      wa  = AW'($urandom_range(0, 3));
      wd  = DW'($urandom);
      re  = 1'($urandom_range(0, 1));
      ra  = AW'($urandom_range(0, 3));
      clr = ($urandom_range(0, 99) == 0);
      step();
    end
    idle();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
